// File: rtl/regfile_sequencer.sv
// Sequencer that serialises decode reads (two operands) and writeback writes onto the
// single port of an x0-x7 register file, alternating grants under contention.
module regfile_sequencer #(
    parameter int DATA_W  = 6,
    parameter int ADDR_W  = 3,
    parameter bit SKIP_X0 = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    output logic [DATA_W-1:0] opa,
    output logic [DATA_W-1:0] opb,
    output logic              op_valid,
    input  logic              op_ready,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              rf_we,
    input  logic [DATA_W-1:0] rf_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD1,
        RD2,
        DONE
    } state_t;

    typedef enum logic {
        GRANT_READ  = 1'b0,
        GRANT_WRITE = 1'b1
    } grant_t;

    state_t            state_q, state_d;
    grant_t            last_grant_q, last_grant_d;
    logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
    logic              rf_we_q, rf_we_d;
    logic [DATA_W-1:0] opa_q, opa_d;
    logic [DATA_W-1:0] opb_q, opb_d;
    logic              op_valid_q, op_valid_d;
    logic [ADDR_W-1:0] rs2_q, rs2_d;
    logic              wb_grant, rd_grant;

    // Writeback takes the port unless it had the previous grant and a read is waiting.
    always_comb begin
        wb_grant = (state_q == IDLE) && wb_valid && !(rd_valid && last_grant_q == GRANT_WRITE);
        rd_grant = (state_q == IDLE) && rd_valid && !wb_grant;
    end

    // NOTE: every signal gets a default before the case so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        rf_addr_d    = rf_addr_q;
        rf_wdata_d   = rf_wdata_q;
        rf_we_d      = 1'b0;
        opa_d        = opa_q;
        opb_d        = opb_q;
        op_valid_d   = op_valid_q;
        rs2_d        = rs2_q;

        case (state_q)
            IDLE: begin
                if (wb_grant) begin
                    last_grant_d = GRANT_WRITE;
                    if (!(SKIP_X0 && wb_addr == '0)) begin
                        rf_addr_d  = wb_addr;
                        rf_wdata_d = wb_data;
                        rf_we_d    = 1'b1;
                        state_d    = WR;
                    end
                end else if (rd_grant) begin
                    last_grant_d = GRANT_READ;
                    rs2_d        = rs2;
                    if (SKIP_X0 && rs1 == '0) begin
                        opa_d = '0;
                        if (rs2 == '0) begin
                            opb_d   = '0;
                            state_d = DONE;
                        end else begin
                            rf_addr_d = rs2;
                            state_d   = RD2;
                        end
                    end else begin
                        rf_addr_d = rs1;
                        state_d   = RD1;
                    end
                end
            end
            WR: state_d = IDLE;
            RD1: begin
                opa_d = rf_rdata;
                if (SKIP_X0 && rs2_q == '0) begin
                    opb_d   = '0;
                    state_d = DONE;
                end else begin
                    rf_addr_d = rs2_q;
                    state_d   = RD2;
                end
            end
            RD2: begin
                opb_d   = rf_rdata;
                state_d = DONE;
            end
            DONE: begin
                // op_valid rises one cycle after entering DONE and drops on the consuming edge.
                op_valid_d = 1'b1;
                if (op_valid_q && op_ready) begin
                    op_valid_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_READ;
            rf_addr_q    <= '0;
            rf_wdata_q   <= '0;
            rf_we_q      <= 1'b0;
            opa_q        <= '0;
            opb_q        <= '0;
            op_valid_q   <= 1'b0;
            rs2_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            rf_addr_q    <= rf_addr_d;
            rf_wdata_q   <= rf_wdata_d;
            rf_we_q      <= rf_we_d;
            opa_q        <= opa_d;
            opb_q        <= opb_d;
            op_valid_q   <= op_valid_d;
            rs2_q        <= rs2_d;
        end
    end

    assign wb_ready = wb_grant;
    assign rd_ready = rd_grant;
    assign rf_addr  = rf_addr_q;
    assign rf_wdata = rf_wdata_q;
    assign rf_we    = rf_we_q;
    assign opa      = opa_q;
    assign opb      = opb_q;
    assign op_valid = op_valid_q;

endmodule
